ksa_checker: RTL and testbench

Synthesizable response checker for the ksa adder, the consuming end of the ksa stimulus interface. It observes each applied vector (a, b, c_in) and the DUT sum, computes the golden sum internally, and aligns it to the DUT's pipeline latency. It counts vectors and mismatches, captures the first failing vector, and reports pass or fail after a programmed number of vectors. It sits next to ksa in BIST/FPGA builds and in benches as a self-check monitor.

---
 rtl/ksa_checker_pkg.sv | 13 +
 rtl/ksa_checker_ref_pipe.sv | 72 +++++++
 rtl/ksa_checker.sv | 159 +++++++++++++++
 tb/tb_ksa_checker.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ksa_checker_pkg.sv
// ksa_checker_pkg: state encoding and default operand width shared by the
// ksa adder family and its response checker.
package ksa_checker_pkg;

    localparam int KSA_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ksa_state_t;

endpackage

// File: rtl/ksa_checker_ref_pipe.sv
// ksa_ref_pipe: golden ksa sum plus a LATENCY-deep shift register that carries
// the vector and its expected sum so they line up with the DUT result.
// LATENCY=0 is a pure combinational pass-through. Only the valids are reset or
// flushed; the data stages are free-running.
module ksa_ref_pipe
    import ksa_checker_pkg::*;
#(
    parameter int WIDTH   = KSA_DEFAULT_WIDTH,
    parameter int LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic             o_cin,
    output logic [WIDTH:0]   o_exp
);

    localparam int DW = 3 * WIDTH + 2;

    logic [WIDTH:0] w_exp_p0;
    logic [DW-1:0]  w_data_p0;
    logic [DW-1:0]  w_data_pn;

    // Full-width golden sum: the carry-out is kept, never truncated.
    assign w_exp_p0  = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    assign w_data_p0 = {i_a, i_b, i_cin, w_exp_p0};

    generate
        if (LATENCY == 0) begin : g_comb
            logic w_unused_ctl;
            assign w_unused_ctl = ^{clk, rst, i_flush};
            assign o_vld        = i_vld;
            assign w_data_pn    = w_data_p0;
        end else begin : g_pipe
            logic [LATENCY-1:0] r_vld_p;
            logic [DW-1:0]      r_data_p [LATENCY];

            // valid shift register, cleared on reset or flush
            always_ff @(posedge clk) begin
                if (rst || i_flush) begin
                    r_vld_p <= '0;
                end else begin
                    r_vld_p[0] <= i_vld;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_vld_p[i] <= r_vld_p[i-1];
                    end
                end
            end

            // data shift register, no reset needed
            always_ff @(posedge clk) begin
                r_data_p[0] <= w_data_p0;
                for (int i = 1; i < LATENCY; i++) begin
                    r_data_p[i] <= r_data_p[i-1];
                end
            end

            assign o_vld     = r_vld_p[LATENCY-1];
            assign w_data_pn = r_data_p[LATENCY-1];
        end
    endgenerate

    assign {o_a, o_b, o_cin, o_exp} = w_data_pn;

endmodule

// File: rtl/ksa_checker.sv
// ksa_checker: response checker for the ksa adder. Compares the DUT sum with a
// latency-aligned golden sum, counts vectors and (saturating) mismatches,
// captures the first failing vector and reports pass/fail after NUM_VECTORS.
// Optional build macro KSA_CHK_HALT_ON_ERR_EN: stop the run at the first mismatch.
module ksa_checker
    import ksa_checker_pkg::*;
#(
    parameter int WIDTH       = KSA_DEFAULT_WIDTH,
    parameter int LATENCY     = 0,
    parameter int NUM_VECTORS = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [WIDTH:0]   sum,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [15:0]      vec_cnt,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_cin,
    output logic [WIDTH:0]   fail_sum,
    output logic [WIDTH:0]   fail_exp
);

    localparam logic [15:0] NUM_VEC  = 16'(NUM_VECTORS);
    localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

    ksa_state_t       r_state;
    ksa_state_t       w_next;
    logic             w_flush;
    logic             w_pipe_vld;
    logic [WIDTH-1:0] w_pipe_a;
    logic [WIDTH-1:0] w_pipe_b;
    logic             w_pipe_cin;
    logic [WIDTH:0]   w_pipe_exp;
    logic             w_strobe;
    logic             w_mis;
    logic             w_last;
    logic             w_halt;
    logic             w_run_entry;
    logic [CNT_W-1:0] r_err_cnt;
    logic [15:0]      r_vec_cnt;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;
    logic             r_fail_cin;
    logic [WIDTH:0]   r_fail_sum;
    logic [WIDTH:0]   r_fail_exp;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Anything in flight while not running is discarded, so a run starts empty.
    assign w_flush = (r_state != ST_RUN);

    ksa_ref_pipe #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_ref_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_vld   (vld_in),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (c_in),
        .o_vld   (w_pipe_vld),
        .o_a     (w_pipe_a),
        .o_b     (w_pipe_b),
        .o_cin   (w_pipe_cin),
        .o_exp   (w_pipe_exp)
    );

    assign w_strobe    = w_pipe_vld && (r_state == ST_RUN) && (r_vec_cnt < NUM_VEC);
    assign w_mis       = w_strobe && (sum != w_pipe_exp);
    assign w_last      = w_strobe && (r_vec_cnt == LAST_VEC);
    assign w_run_entry = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

`ifdef KSA_CHK_HALT_ON_ERR_EN
    assign w_halt = w_mis;
`else
    assign w_halt = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next state and status outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        pass   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last || w_halt) w_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                pass = (r_err_cnt == '0);
                if (start) w_next = ST_RUN;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // counters and first-failure capture, cleared on every run entry
    always_ff @(posedge clk) begin
        if (rst || w_run_entry) begin
            r_err_cnt  <= '0;
            r_vec_cnt  <= '0;
            r_fail_a   <= '0;
            r_fail_b   <= '0;
            r_fail_cin <= 1'b0;
            r_fail_sum <= '0;
            r_fail_exp <= '0;
        end else if (w_strobe) begin
            r_vec_cnt <= r_vec_cnt + 16'd1;
            if (w_mis) begin
                r_err_cnt <= sat_inc(r_err_cnt);
                // a zero count means this is the first mismatch of the run
                if (r_err_cnt == '0) begin
                    r_fail_a   <= w_pipe_a;
                    r_fail_b   <= w_pipe_b;
                    r_fail_cin <= w_pipe_cin;
                    r_fail_sum <= sum;
                    r_fail_exp <= w_pipe_exp;
                end
            end
        end
    end

    assign err_cnt  = r_err_cnt;
    assign vec_cnt  = r_vec_cnt;
    assign fail_a   = r_fail_a;
    assign fail_b   = r_fail_b;
    assign fail_cin = r_fail_cin;
    assign fail_sum = r_fail_sum;
    assign fail_exp = r_fail_exp;

endmodule

// File: tb/tb_ksa_checker.sv
// tb_ksa_checker: scoreboard bench for ksa_checker. Instance 0 checks a
// combinational DUT model (LATENCY=0, CNT_W=2) with injectable sum faults;
// instance 1 checks a two-register DUT model (LATENCY=2) that can be switched
// to a one-register path. Honours KSA_CHK_HALT_ON_ERR_EN when defined.
module tb_ksa_checker;

`ifdef KSA_CHK_HALT_ON_ERR_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    typedef struct {
        logic [15:0] vec;
        logic [7:0]  err;
        logic        pass;
        logic [3:0]  fa;
        logic [3:0]  fb;
        logic        fc;
        logic [4:0]  fs;
        logic [4:0]  fe;
    } exp_t;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       vld    = 1'b0;
    logic [3:0] a      = '0;
    logic [3:0] b      = '0;
    logic       cin    = 1'b0;
    logic [4:0] mask   = '0;
    logic       lag    = 1'b0;
    logic [4:0] sum0, sum1;
    logic [4:0] r_d1, r_d2;

    logic        busy0, done0, pass0, fc0;
    logic [1:0]  err0;
    logic [15:0] vec0;
    logic [3:0]  fa0, fb0;
    logic [4:0]  fs0, fe0;
    logic        busy1, done1, pass1, fc1;
    logic [7:0]  err1;
    logic [15:0] vec1;
    logic [3:0]  fa1, fb1;
    logic [4:0]  fs1, fe1;

    logic [3:0] va [16];
    logic [3:0] vb [16];
    logic       vc [16];
    logic [4:0] vm [16];

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    function automatic logic [4:0] gold(input logic [3:0] x, input logic [3:0] y, input logic c);
        int t;
        t = int'(x) + int'(y) + int'(c);
        return 5'(t);
    endfunction

    // combinational DUT with fault mask; registered DUT with selectable depth
    assign sum0 = gold(a, b, cin) ^ mask;
    always @(posedge clk) begin
        r_d1 <= gold(a, b, cin);
        r_d2 <= r_d1;
    end
    assign sum1 = lag ? r_d1 : r_d2;

    ksa_checker #(.WIDTH(4), .LATENCY(0), .NUM_VECTORS(16), .CNT_W(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .vld_in(vld), .a(a), .b(b), .c_in(cin),
        .sum(sum0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .vec_cnt(vec0), .fail_a(fa0), .fail_b(fb0), .fail_cin(fc0),
        .fail_sum(fs0), .fail_exp(fe0)
    );

    ksa_checker #(.WIDTH(4), .LATENCY(2), .NUM_VECTORS(16), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .vld_in(vld), .a(a), .b(b), .c_in(cin),
        .sum(sum1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .vec_cnt(vec1), .fail_a(fa1), .fail_b(fb1), .fail_cin(fc1),
        .fail_sum(fs1), .fail_exp(fe1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 16; i++) begin
            va[i] = 4'(3 * i);
            vb[i] = 4'(4 * i);
            vc[i] = 1'b0;
            vm[i] = 5'h00;
        end
    endtask

    task automatic check_zero0(input string pfx);
        check({pfx, "_busy"}, busy0, 0);
        check({pfx, "_done"}, done0, 0);
        check({pfx, "_pass"}, pass0, 0);
        check({pfx, "_err"},  err0, 0);
        check({pfx, "_vec"},  vec0, 0);
        check({pfx, "_fa"},   fa0, 0);
        check({pfx, "_fb"},   fb0, 0);
        check({pfx, "_fs"},   fs0, 0);
        check({pfx, "_fe"},   fe0, 0);
    endtask

    task automatic wait_done0(input string pfx);
        exp_t e;
        int   k = 0;
        while (!done0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({pfx, "_done"}, done0, 1);
        if (q0.size() == 0) begin
            check({pfx, "_sb_empty"}, 0, 1);
            return;
        end
        e = q0.pop_front();
        check({pfx, "_busy"}, busy0, 0);
        check({pfx, "_vec"},  vec0, e.vec);
        check({pfx, "_err"},  err0, e.err);
        check({pfx, "_pass"}, pass0, e.pass);
        check({pfx, "_fa"},   fa0, e.fa);
        check({pfx, "_fb"},   fb0, e.fb);
        check({pfx, "_fc"},   fc0, e.fc);
        check({pfx, "_fs"},   fs0, e.fs);
        check({pfx, "_fe"},   fe0, e.fe);
    endtask

    // Drives va/vb/vc/vm to instance 0; the reference model builds the
    // expected result record as each vector goes out.
    task automatic run_dut0(input string pfx, input int rst_at, input int restart_at);
        exp_t       e;
        int         m_vec = 0;
        int         m_err = 0;
        bit         halted = 1'b0;
        logic [4:0] g, s;
        e = '{default: '0};
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check({pfx, "_busy_run"}, busy0, 1);
        for (int i = 0; i < 16; i++) begin
            vld    = 1'b1;
            a      = va[i];
            b      = vb[i];
            cin    = vc[i];
            mask   = vm[i];
            start0 = (i == restart_at);
            rst    = (i == rst_at);
            g = gold(va[i], vb[i], vc[i]);
            s = g ^ vm[i];
            if (!halted && i != rst_at) begin
                m_vec++;
                if (s != g) begin
                    if (m_err == 0) begin
                        e.fa = va[i];
                        e.fb = vb[i];
                        e.fc = vc[i];
                        e.fs = s;
                        e.fe = g;
                    end
                    if (m_err < 3) m_err++;
                    if (HALT) halted = 1'b1;
                end
            end
            @(negedge clk);
            if (i == rst_at) begin
                rst    = 1'b0;
                vld    = 1'b0;
                start0 = 1'b0;
                mask   = '0;
                check_zero0({pfx, "_rst"});
                return;
            end
        end
        vld    = 1'b0;
        start0 = 1'b0;
        mask   = '0;
        e.vec  = 16'(m_vec);
        e.err  = 8'(m_err);
        e.pass = (m_err == 0);
        q0.push_back(e);
        wait_done0(pfx);
    endtask

    // Instance 1: ramp vectors through the registered DUT model.
    task automatic run_dut1(input string pfx, input bit lg);
        exp_t e;
        int   k = 0;
        e   = '{default: '0};
        lag = lg;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            vld = 1'b1;
            a   = 4'(3 * i);
            b   = 4'(4 * i);
            cin = 1'b0;
            @(negedge clk);
        end
        vld    = 1'b0;
        a      = '0;
        b      = '0;
        e.vec  = 16'd16;
        e.pass = !lg;
        e.err  = {7'd0, lg};
        q1.push_back(e);
        while (!done1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({pfx, "_done"}, done1, 1);
        if (q1.size() == 0) begin
            check({pfx, "_sb_empty"}, 0, 1);
            return;
        end
        e = q1.pop_front();
        check({pfx, "_pass"}, pass1, e.pass);
        check({pfx, "_err_nz"}, (err1 != 0), e.err);
        if (!lg) check({pfx, "_vec"}, vec1, e.vec);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero0("reset0");
        check("reset1_busy", busy1, 0);
        check("reset1_done", done1, 0);
        check("reset1_vec",  vec1, 0);
        rst = 1'b0;

        // clean ramp, with a start pulse mid-run that must be ignored
        fill_ramp();
        run_dut0("clean", -1, 8);

        // sum bit 0 flipped on vector 5 (F + 4 = 13h, DUT gives 12h)
        fill_ramp();
        vm[5] = 5'h01;
        run_dut0("fault5", -1, -1);

        // wrap-around boundary: F + F + 1 = 1Fh, first correct then wrong (0Fh)
        fill_ramp();
        va[0] = 4'hF;
        vb[0] = 4'hF;
        vc[0] = 1'b1;
        run_dut0("wrap_ok", -1, -1);
        vm[0] = 5'h10;
        run_dut0("wrap_bad", -1, -1);

        // every sum wrong: error count saturates at 3 (or halts at vector 1)
        fill_ramp();
        for (int i = 0; i < 16; i++) vm[i] = 5'h01;
        run_dut0("sat", -1, -1);

        // reset mid-run after an error, then a fresh clean run
        fill_ramp();
        vm[3] = 5'h04;
        run_dut0("midrst", 7, -1);
        fill_ramp();
        run_dut0("after_rst", -1, -1);

        // latency alignment: matching depth passes, one-cycle-short DUT fails
        run_dut1("lat2", 1'b0);
        run_dut1("lat1", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
